// File: rtl/bus_memory_controller_pkg.sv
// Shared definitions for the bus memory controller: region geometry, timer
// register offsets, controller FSM states and the region decode helper.
package BusMapTypes;

    localparam logic [31:0] MEM_BASE_DEF      = 32'h8000_0000;
    localparam int          MEM_SIZE_LOG2_DEF = 16;
    localparam logic [31:0] TIMER_BASE_DEF    = 32'h4000_0000;
    localparam int          TIMER_SIZE_LOG2   = 4;

    localparam logic [1:0] TMR_MTIME_LO = 2'd0;
    localparam logic [1:0] TMR_MTIME_HI = 2'd1;
    localparam logic [1:0] TMR_CMP_LO   = 2'd2;
    localparam logic [1:0] TMR_CMP_HI   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_WAIT,
        ST_RESP
    } bus_state_e;

    // Regions are aligned to their own size, so masking the offset bits is enough.
    function automatic logic region_hit(input logic [31:0] a, input logic [31:0] base,
                                        input int size_log2);
        logic [31:0] mask;
        mask = ~((32'd1 << size_log2) - 32'd1);
        return (a & mask) == base;
    endfunction

endpackage

// File: rtl/bus_memory_controller_timer.sv
// Machine timer: prescaled 64-bit mtime, 64-bit mtimecmp, registered compare
// interrupt and a 32-bit read mux selected by the word offset.
module bus_timer
    import BusMapTypes::*;
#(
    parameter int TIMER_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam int             PW       = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(TIMER_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   cmp_q, cmp_d;
    logic          irq_q;
    logic          tick;
    logic [63:0]   mtime_inc;

    // A half-word write overrides only its half; the other half keeps the increment.
    always_comb begin
        tick      = (pre_q == PRE_LAST);
        pre_d     = tick ? '0 : pre_q + 1'b1;
        mtime_inc = mtime_q + {63'd0, tick};
        mtime_d   = mtime_inc;
        cmp_d     = cmp_q;
        if (wr_en_i) begin
            case (off_i)
                TMR_MTIME_LO: mtime_d[31:0]  = wdata_i;
                TMR_MTIME_HI: mtime_d[63:32] = wdata_i;
                TMR_CMP_LO:   cmp_d[31:0]    = wdata_i;
                TMR_CMP_HI:   cmp_d[63:32]   = wdata_i;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q   <= '0;
            mtime_q <= 64'd0;
            cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
            irq_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            irq_q   <= (mtime_d >= cmp_d);
        end
    end

    always_comb begin
        case (off_i)
            TMR_MTIME_LO: rdata_o = mtime_q[31:0];
            TMR_MTIME_HI: rdata_o = mtime_q[63:32];
            TMR_CMP_LO:   rdata_o = cmp_q[31:0];
            default:      rdata_o = cmp_q[63:32];
        endcase
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/bus_memory_controller.sv
// Bus slave for the two-phase select/enable bus: decodes the SRAM and machine
// timer regions, sequences fixed-latency SRAM reads and returns rdata/ready.
module bus_memory_controller
    import BusMapTypes::*;
#(
    parameter logic [31:0] MEM_BASE      = MEM_BASE_DEF,
    parameter int          MEM_SIZE_LOG2 = MEM_SIZE_LOG2_DEF,
    parameter int          MEM_LATENCY   = 2,
    parameter logic [31:0] TIMER_BASE    = TIMER_BASE_DEF,
    parameter int          TIMER_DIV     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              addr,
    input  logic                     select,
    input  logic                     enable,
    input  logic                     write,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     ready,
    output logic                     irqTimer,
    output logic                     memReq,
    output logic                     memWrite,
    output logic [MEM_SIZE_LOG2-3:0] memAddr,
    output logic [31:0]              memWdata,
    input  logic [31:0]              memRdata
);

    localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY - 1);

    bus_state_e  state_q;
    logic [2:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        armed_q, armed_d;
    logic        ram_hit, tmr_hit, accept;
    logic [31:0] tmr_rdata;
    logic        tmr_irq;

    // armed demands a fresh setup phase, so an enable left high after ready cannot re-trigger.
    always_comb begin
        ram_hit = region_hit(addr, MEM_BASE, MEM_SIZE_LOG2);
        tmr_hit = region_hit(addr, TIMER_BASE, TIMER_SIZE_LOG2);
        accept  = (state_q == ST_IDLE) && select && enable && armed_q;
        armed_d = armed_q;
        if (accept) begin
            armed_d = 1'b0;
        end else if (select && !enable) begin
            armed_d = 1'b1;
        end
    end

    assign memReq   = accept && ram_hit;
    assign memWrite = accept && ram_hit && write;
    assign memAddr  = addr[MEM_SIZE_LOG2-1:2];
    assign memWdata = wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
            ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (ram_hit && !write) begin
                            state_q <= ST_MEM_WAIT;
                            cnt_q   <= LAT_INIT;
                        end else begin
                            state_q <= ST_RESP;
                            ready_q <= 1'b1;
                            if (!write) begin
                                rdata_q <= tmr_hit ? tmr_rdata : 32'd0;
                            end
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        rdata_q <= memRdata;
                        state_q <= ST_RESP;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    bus_timer #(
        .TIMER_DIV (TIMER_DIV)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (accept && tmr_hit && write),
        .off_i   (addr[3:2]),
        .wdata_i (wdata),
        .rdata_o (tmr_rdata),
        .irq_o   (tmr_irq)
    );

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign irqTimer = tmr_irq;

endmodule

// File: tb/tb_bus_memory_controller.sv
// Self-checking bench for bus_memory_controller: directed scenarios plus a
// randomized back-to-back stream checked against a behavioural model.
module tb_bus_memory_controller;

    localparam int LAT = 2;
    localparam int MSL = 16;
    localparam int DIV = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = 32'd0;
    logic        select = 1'b0;
    logic        enable = 1'b0;
    logic        write = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic        irqTimer;
    logic        memReq;
    logic        memWrite;
    logic [MSL-3:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_memory_controller #(
        .MEM_BASE      (32'h8000_0000),
        .MEM_SIZE_LOG2 (MSL),
        .MEM_LATENCY   (LAT),
        .TIMER_BASE    (32'h4000_0000),
        .TIMER_DIV     (DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .select   (select),
        .enable   (enable),
        .write    (write),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .irqTimer (irqTimer),
        .memReq   (memReq),
        .memWrite (memWrite),
        .memAddr  (memAddr),
        .memWdata (memWdata),
        .memRdata (memRdata)
    );

    // External synchronous SRAM: data appears LAT cycles after the request cycle.
    logic [31:0] sram [0:(1<<(MSL-2))-1];
    logic [31:0] pipe [0:LAT-1];
    always @(posedge clk) begin
        if (memReq && memWrite) sram[memAddr] <= memWdata;
        pipe[0] <= (memReq && !memWrite) ? sram[memAddr] : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign memRdata = pipe[LAT-1];

    // Behavioural timer model driven by the bench's own notion of the access cycle.
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    int          m_pre;
    logic        tb_wr_en = 1'b0;
    logic [1:0]  tb_wr_off = 2'd0;
    logic [31:0] tb_wr_data = 32'd0;

    function automatic logic [63:0] timer_next(input logic [63:0] t, input logic tick,
                                               input logic we, input logic [1:0] off,
                                               input logic [31:0] d);
        logic [63:0] n;
        n = t + (tick ? 64'd1 : 64'd0);
        if (we && off == 2'd0) n[31:0]  = d;
        if (we && off == 2'd1) n[63:32] = d;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mtime <= 64'd0;
            m_cmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_pre   <= 0;
        end else begin
            m_pre   <= (m_pre == DIV - 1) ? 0 : m_pre + 1;
            m_mtime <= timer_next(m_mtime, m_pre == DIV - 1, tb_wr_en, tb_wr_off, tb_wr_data);
            if (tb_wr_en && tb_wr_off == 2'd2) m_cmp[31:0]  <= tb_wr_data;
            if (tb_wr_en && tb_wr_off == 2'd3) m_cmp[63:32] <= tb_wr_data;
        end
    end

    logic [31:0] model_mem [int];
    logic [31:0] model_rdata = 32'd0;
    int          wq[$];

    function automatic logic is_ram(input logic [31:0] a);
        return a[31:MSL] == 16'h8000;
    endfunction

    function automatic logic is_tmr(input logic [31:0] a);
        return a[31:4] == 28'h400_0000;
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
        logic [31:0] memaddr;
        logic [31:0] memwdata;
        int          lat;
        int          exp_lat;
        logic        memreq;
        logic        memwrite;
        logic        ready_setup;
    } xfer_t;

    task automatic idle_bus();
        @(posedge clk); #1;
        select = 1'b0;
        enable = 1'b0;
        write  = 1'b0;
    endtask

    // One bus transfer: setup, access until ready. Returns observations and model expectations.
    task automatic do_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                           output xfer_t r);
        int w;
        w = int'(a[MSL-1:2]);
        @(posedge clk); #1;
        r.ready_setup = ready;
        addr = a; write = wr; wdata = wd; select = 1'b1; enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        if (is_tmr(a) && wr) begin
            tb_wr_en = 1'b1; tb_wr_off = a[3:2]; tb_wr_data = wd;
        end
        r.exp_lat = (is_ram(a) && !wr) ? LAT + 1 : 1;
        if (!wr) begin
            if (is_ram(a)) model_rdata = model_mem.exists(w) ? model_mem[w] : 32'd0;
            else if (is_tmr(a)) begin
                case (a[3:2])
                    2'd0: model_rdata = m_mtime[31:0];
                    2'd1: model_rdata = m_mtime[63:32];
                    2'd2: model_rdata = m_cmp[31:0];
                    default: model_rdata = m_cmp[63:32];
                endcase
            end else model_rdata = 32'd0;
        end else if (is_ram(a)) begin
            model_mem[w] = wd;
        end
        r.exp_rdata = model_rdata;
        #1;
        r.memreq   = memReq;
        r.memwrite = memWrite;
        r.memaddr  = 32'(memAddr);
        r.memwdata = memWdata;
        r.lat = 0;
        do begin
            @(posedge clk); #1;
            tb_wr_en = 1'b0;
            r.lat++;
        end while (!ready && r.lat < 20);
        r.rdata = rdata;
        $display("xfer a=%h wr=%0d wd=%h rdata=%h lat=%0d", a, wr, wd, r.rdata, r.lat);
    endtask

    task automatic test_reset();
        xfer_t r;
        int    n;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (ready !== 1'b0)    begin errors++; $display("FAIL rst_ready: got %b want 0", ready); end
        if (rdata !== 32'd0)   begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        if (memReq !== 1'b0)   begin errors++; $display("FAIL rst_memreq: got %b want 0", memReq); end
        if (irqTimer !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irqTimer); end
        rst = 1'b1;
        @(posedge clk); #1;
        addr = 32'h8000_0040; write = 1'b0; select = 1'b1; enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        checks += 3;
        if (ready !== 1'b0)    begin errors++; $display("FAIL midrst_ready: got %b want 0", ready); end
        if (memReq !== 1'b0)   begin errors++; $display("FAIL midrst_memreq: got %b want 0", memReq); end
        if (irqTimer !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b want 0", irqTimer); end
        select = 1'b0; enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL midrst_stale_ready: got %0d pulses want 0", n); end
        do_xfer(32'h4000_000C, 1'b0, 32'd0, r);
        checks += 2;
        if (r.rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmp_hi: got %h want ffffffff", r.rdata); end
        if (r.lat != 1) begin errors++; $display("FAIL rst_cmp_lat: got %0d want 1", r.lat); end
        idle_bus();
    endtask

    task automatic test_ram_write();
        xfer_t r;
        do_xfer(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, r);
        checks += 6;
        if (r.memreq !== 1'b1)   begin errors++; $display("FAIL wr_memreq: got %b want 1", r.memreq); end
        if (r.memwrite !== 1'b1) begin errors++; $display("FAIL wr_memwrite: got %b want 1", r.memwrite); end
        if (r.memaddr !== 32'd4) begin errors++; $display("FAIL wr_memaddr: got %0d want 4", r.memaddr); end
        if (r.memwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_memwdata: got %h want deadbeef", r.memwdata); end
        if (r.lat != 1) begin errors++; $display("FAIL wr_lat: got %0d want 1", r.lat); end
        if (r.rdata !== r.exp_rdata) begin errors++; $display("FAIL wr_rdata_hold: got %h want %h", r.rdata, r.exp_rdata); end
        wq.push_back(4);
        idle_bus();
    endtask

    task automatic test_ram_read();
        xfer_t r;
        do_xfer(32'h8000_0020, 1'b1, 32'h1234_5678, r);
        do_xfer(32'h8000_0022, 1'b0, 32'd0, r);
        checks += 5;
        if (r.memreq !== 1'b1)   begin errors++; $display("FAIL rd_memreq: got %b want 1", r.memreq); end
        if (r.memwrite !== 1'b0) begin errors++; $display("FAIL rd_memwrite: got %b want 0", r.memwrite); end
        if (r.memaddr !== 32'd8) begin errors++; $display("FAIL rd_memaddr: got %0d want 8", r.memaddr); end
        if (r.lat != LAT + 1)    begin errors++; $display("FAIL rd_lat: got %0d want %0d", r.lat, LAT + 1); end
        if (r.rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h want 12345678", r.rdata); end
        do_xfer(32'h8000_0013, 1'b0, 32'd0, r);
        checks++;
        if (r.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data2: got %h want deadbeef", r.rdata); end
        do_xfer(32'h8000_FFFC, 1'b1, 32'hA5A5_5A5A, r);
        do_xfer(32'h8000_FFFC, 1'b0, 32'd0, r);
        checks += 2;
        if (r.memaddr !== 32'd16383) begin errors++; $display("FAIL rd_top_addr: got %0d want 16383", r.memaddr); end
        if (r.rdata !== 32'hA5A5_5A5A) begin errors++; $display("FAIL rd_top_data: got %h want a5a55a5a", r.rdata); end
        wq.push_back(8);
        wq.push_back(16383);
        idle_bus();
    endtask

    task automatic test_unmapped();
        xfer_t r;
        int    n;
        do_xfer(32'h8000_0020, 1'b0, 32'd0, r);
        do_xfer(32'h1000_0000, 1'b1, 32'hCAFE_F00D, r);
        checks += 3;
        if (r.memreq !== 1'b0) begin errors++; $display("FAIL um_wr_memreq: got %b want 0", r.memreq); end
        if (r.lat != 1) begin errors++; $display("FAIL um_wr_lat: got %0d want 1", r.lat); end
        if (r.rdata !== 32'h1234_5678) begin errors++; $display("FAIL um_wr_hold: got %h want 12345678", r.rdata); end
        do_xfer(32'h8001_0000, 1'b0, 32'd0, r);
        checks += 3;
        if (r.memreq !== 1'b0) begin errors++; $display("FAIL um_edge_memreq: got %b want 0", r.memreq); end
        if (r.rdata !== 32'd0) begin errors++; $display("FAIL um_edge_rdata: got %h want 0", r.rdata); end
        if (r.lat != 1) begin errors++; $display("FAIL um_edge_lat: got %0d want 1", r.lat); end
        do_xfer(32'h8000_0010, 1'b0, 32'd0, r);
        do_xfer(32'h1000_0000, 1'b0, 32'd0, r);
        checks += 2;
        if (r.rdata !== 32'd0) begin errors++; $display("FAIL um_rdata: got %h want 0", r.rdata); end
        if (r.lat != 1) begin errors++; $display("FAIL um_lat: got %0d want 1", r.lat); end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL um_retrigger: got %0d pulses want 0", n); end
        idle_bus();
    endtask

    task automatic test_timer_irq();
        xfer_t       r;
        logic        seen;
        logic [63:0] rise_mt;
        do_xfer(32'h4000_0000, 1'b1, 32'd0, r);
        do_xfer(32'h4000_000C, 1'b1, 32'd0, r);
        do_xfer(32'h4000_0008, 1'b1, 32'd20, r);
        idle_bus();
        seen = 1'b0;
        rise_mt = 64'd0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            checks++;
            if (irqTimer !== (m_mtime >= m_cmp)) begin
                errors++;
                $display("FAIL irq_track: got %b want %b mtime=%0d", irqTimer, (m_mtime >= m_cmp), m_mtime);
            end
            if (irqTimer === 1'b1 && !seen) begin seen = 1'b1; rise_mt = m_mtime; end
        end
        checks++;
        if (!seen || rise_mt !== 64'd20) begin errors++; $display("FAIL irq_rise: seen=%b at mtime=%0d want 20", seen, rise_mt); end
        do_xfer(32'h4000_000C, 1'b1, 32'd1, r);
        checks++;
        if (irqTimer !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b want 0", irqTimer); end
        do_xfer(32'h4000_000C, 1'b1, 32'd0, r);
        checks++;
        if (irqTimer !== 1'b1) begin errors++; $display("FAIL irq_rearm: got %b want 1", irqTimer); end
        idle_bus();
    endtask

    task automatic test_mtime_wrap();
        xfer_t r;
        do_xfer(32'h4000_0004, 1'b1, 32'd0, r);
        do_xfer(32'h4000_0000, 1'b1, 32'hFFFF_FFFF, r);
        do_xfer(32'h4000_0004, 1'b0, 32'd0, r);
        checks += 2;
        if (r.rdata !== 32'd1) begin errors++; $display("FAIL wrap_hi: got %h want 1", r.rdata); end
        if (r.rdata !== r.exp_rdata) begin errors++; $display("FAIL wrap_hi_model: got %h want %h", r.rdata, r.exp_rdata); end
        do_xfer(32'h4000_0000, 1'b0, 32'd0, r);
        checks++;
        if (r.rdata !== r.exp_rdata) begin errors++; $display("FAIL wrap_lo: got %h want %h", r.rdata, r.exp_rdata); end
        do_xfer(32'h4000_0004, 1'b1, 32'd7, r);
        do_xfer(32'h4000_0004, 1'b0, 32'd0, r);
        checks++;
        if (r.rdata !== 32'd7) begin errors++; $display("FAIL collide_hi: got %h want 7", r.rdata); end
        do_xfer(32'h4000_0000, 1'b0, 32'd0, r);
        checks++;
        if (r.rdata !== r.exp_rdata) begin errors++; $display("FAIL collide_lo: got %h want %h", r.rdata, r.exp_rdata); end
        idle_bus();
    endtask

    task automatic test_back_to_back();
        xfer_t       r;
        logic [31:0] a;
        logic        wr;
        int          kind;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            wr = $urandom_range(0, 1) == 1;
            if (kind < 5) begin
                if (wr || wq.size() == 0) begin
                    wr = 1'b1;
                    a = 32'h8000_0000 | (32'($urandom_range(0, 16383)) << 2) | 32'($urandom_range(0, 3));
                    wq.push_back(int'(a[MSL-1:2]));
                end else begin
                    a = 32'h8000_0000 | (32'(wq[$urandom_range(0, wq.size() - 1)]) << 2);
                end
            end else if (kind < 8) begin
                a = 32'h4000_0000 | (32'($urandom_range(0, 3)) << 2);
            end else begin
                a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
            end
            do_xfer(a, wr, $urandom, r);
            checks += 4;
            if (r.ready_setup !== 1'b0) begin errors++; $display("FAIL b2b_ready_setup[%0d]: got %b want 0", i, r.ready_setup); end
            if (r.lat != r.exp_lat) begin errors++; $display("FAIL b2b_lat[%0d] a=%h: got %0d want %0d", i, a, r.lat, r.exp_lat); end
            if (r.rdata !== r.exp_rdata) begin errors++; $display("FAIL b2b_rdata[%0d] a=%h: got %h want %h", i, a, r.rdata, r.exp_rdata); end
            if (irqTimer !== (m_mtime >= m_cmp)) begin errors++; $display("FAIL b2b_irq[%0d]: got %b want %b", i, irqTimer, (m_mtime >= m_cmp)); end
        end
        idle_bus();
    endtask

    initial begin
        test_reset();
        test_ram_write();
        test_ram_read();
        test_unmapped();
        test_timer_irq();
        test_mtime_wrap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
